// File: rtl/lynx_scandoubler.sv
// Line doubler for the Lynx PAL video path: each 15 kHz input line is captured into one
// buffer bank while the other bank is replayed twice at the output pixel rate.
module lynx_scandoubler #(
    parameter int ADDRW   = 9,
    parameter int LINELEN = 448,
    parameter int HSSTART = 344,
    parameter int HSWIDTH = 54
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ceIn,
    input  logic       ceOut,
    input  logic       dbl,
    input  logic       scanlines,
    input  logic [8:0] rgbIn,
    input  logic       hSyncIn,
    input  logic       vSyncIn,
    output logic [1:0] sync,
    output logic [8:0] rgb
);
    localparam logic [ADDRW-1:0] CNT_MAX = '1;
    localparam logic [ADDRW-1:0] CNT_ONE = ADDRW'(1);
    localparam logic [ADDRW-1:0] LEN_RST = ADDRW'(LINELEN);
    localparam logic [ADDRW:0]   EXT_ONE = (ADDRW+1)'(1);
    localparam logic [ADDRW:0]   HS_BEG  = (ADDRW+1)'(HSSTART);
    localparam logic [ADDRW:0]   HS_END  = (ADDRW+1)'(HSSTART + HSWIDTH);

    logic [8:0]       r_buf [2**(ADDRW+1)];
    logic             r_bank;
    logic             r_hs_prev;
    logic             r_line_out;
    logic [ADDRW-1:0] r_hcnt_in;
    logic [ADDRW-1:0] r_hcnt_out;
    logic [ADDRW-1:0] r_line_len;
    logic [8:0]       r_rgb;
    logic [1:0]       r_sync;

    logic             w_hs_rise;
    logic             w_wr_en;
    logic             w_wrap;
    logic             w_hs_act;
    logic [8:0]       w_rd_pix;
    logic [8:0]       w_shaded;

    assign w_hs_rise = ceIn & hSyncIn & ~r_hs_prev;
    assign w_wr_en   = ceIn & ~w_hs_rise & (r_hcnt_in != CNT_MAX);
    // Compared one bit wider so a zero line length cannot underflow.
    assign w_wrap    = ({1'b0, r_hcnt_out} + EXT_ONE) >= {1'b0, r_line_len};
    assign w_hs_act  = ({1'b0, r_hcnt_out} >= HS_BEG) && ({1'b0, r_hcnt_out} < HS_END);
    assign w_rd_pix  = r_buf[{~r_bank, r_hcnt_out}];
    assign w_shaded  = {1'b0, w_rd_pix[8:7], 1'b0, w_rd_pix[5:4], 1'b0, w_rd_pix[2:1]};

    // The buffer is not reset; stale contents only show during the first two output lines.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_buf[{r_bank, r_hcnt_in}] <= rgbIn;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hs_prev  <= 1'b0;
            r_hcnt_in  <= '0;
            r_bank     <= 1'b0;
            r_line_len <= LEN_RST;
        end else if (ceIn) begin
            r_hs_prev <= hSyncIn;
            if (w_hs_rise) begin
                r_line_len <= r_hcnt_in;
                r_hcnt_in  <= '0;
                r_bank     <= ~r_bank;
            end else if (r_hcnt_in != CNT_MAX) begin
                r_hcnt_in <= r_hcnt_in + CNT_ONE;
            end
        end
    end

    // Input hsync realigns the replay every line and wins over the normal wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hcnt_out <= '0;
            r_line_out <= 1'b0;
        end else if (ceOut) begin
            if (w_hs_rise) begin
                r_hcnt_out <= '0;
                r_line_out <= 1'b0;
            end else if (w_wrap) begin
                r_hcnt_out <= '0;
                r_line_out <= ~r_line_out;
            end else begin
                r_hcnt_out <= r_hcnt_out + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rgb  <= '0;
            r_sync <= 2'b11;
        end else if (dbl) begin
            if (ceOut) begin
                r_rgb  <= (scanlines && r_line_out) ? w_shaded : w_rd_pix;
                r_sync <= {~vSyncIn, ~w_hs_act};
            end
        end else if (ceIn) begin
            r_rgb  <= rgbIn;
            r_sync <= {1'b1, ~(hSyncIn | vSyncIn)};
        end
    end

    assign sync = r_sync;
    assign rgb  = r_rgb;

endmodule
